// File: rtl/rob_circular.sv
// Circular reorder buffer: in-order commit, head/tail pointers, N-channel CDB
// capture, occupancy count and synchronous flush.
module rob_circular #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DEST_W  = 5,
    parameter int unsigned NUM_CDB = 6,
    parameter int unsigned IDX_W   = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [DEST_W-1:0]         alloc_dest,
    input  logic [TAG_W-1:0]          alloc_tag,
    input  logic                      alloc_has_value,
    input  logic [DATA_W-1:0]         alloc_value,
    output logic [IDX_W-1:0]          alloc_idx,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    output logic                      commit_valid,
    input  logic                      commit_ready,
    output logic [DEST_W-1:0]         commit_dest,
    output logic [DATA_W-1:0]         commit_data,
    output logic [TAG_W-1:0]          commit_tag,
    output logic [IDX_W-1:0]          commit_idx,
    output logic [DEPTH-1:0]          busy,
    output logic [IDX_W:0]            count,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  rdy_q, rdy_d;
    logic [DEST_W-1:0] dest_q [DEPTH];
    logic [DEST_W-1:0] dest_d [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    logic [DATA_W-1:0] val_q  [DEPTH];
    logic [DATA_W-1:0] val_d  [DEPTH];
    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic alloc_fire;
    logic commit_fire;

    // Status and head-entry view, all decoded directly from registered state
    always_comb begin
        full         = (cnt_q == CNT_W'(DEPTH));
        empty        = (cnt_q == '0);
        alloc_ready  = ~full;
        alloc_idx    = tail_q;
        commit_idx   = head_q;
        commit_valid = busy_q[head_q] & rdy_q[head_q];
        commit_dest  = dest_q[head_q];
        commit_data  = val_q[head_q];
        commit_tag   = tag_q[head_q];
        busy         = busy_q;
        count        = cnt_q;
        alloc_fire   = alloc_valid & ~full;
        commit_fire  = commit_valid & commit_ready;
    end

    // Next state: CDB capture, commit retire, allocation, count, flush override
    always_comb begin
        busy_d = busy_q;
        rdy_d  = rdy_q;
        dest_d = dest_q;
        tag_d  = tag_q;
        val_d  = val_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;

        // Scan channels high to low so the lowest matching channel wins
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (busy_q[i] && !rdy_q[i] && !(alloc_fire && tail_q == IDX_W'(i))) begin
                for (int k = int'(NUM_CDB) - 1; k >= 0; k--) begin
                    if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == tag_q[i]) begin
                        rdy_d[i] = 1'b1;
                        val_d[i] = cdb_data[k*DATA_W +: DATA_W];
                    end
                end
            end
        end

        if (commit_fire) begin
            busy_d[head_q] = 1'b0;
            rdy_d[head_q]  = 1'b0;
            head_d         = head_q + IDX_W'(1);
        end

        if (alloc_fire) begin
            busy_d[tail_q] = 1'b1;
            rdy_d[tail_q]  = alloc_has_value;
            dest_d[tail_q] = alloc_dest;
            tag_d[tail_q]  = alloc_tag;
            val_d[tail_q]  = alloc_value;
            tail_d         = tail_q + IDX_W'(1);
        end

        case ({alloc_fire, commit_fire})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (flush) begin
            busy_d = '0;
            rdy_d  = '0;
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                dest_d[i] = '0;
                tag_d[i]  = '0;
                val_d[i]  = '0;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            rdy_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                dest_q[i] <= '0;
                tag_q[i]  <= '0;
                val_q[i]  <= '0;
            end
        end else begin
            busy_q <= busy_d;
            rdy_q  <= rdy_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                dest_q[i] <= dest_d[i];
                tag_q[i]  <= tag_d[i];
                val_q[i]  <= val_d[i];
            end
        end
    end

endmodule

// File: tb/tb_rob_circular.sv
// Bench for rob_circular: directed scenarios followed by random traffic, all
// checked against a queue-based model of the in-flight instruction window.
module tb_rob_circular;

    localparam int DEPTH   = 8;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 4;
    localparam int DEST_W  = 5;
    localparam int NUM_CDB = 6;
    localparam int IDX_W   = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic alloc_valid;
    logic alloc_ready;
    logic [DEST_W-1:0] alloc_dest;
    logic [TAG_W-1:0]  alloc_tag;
    logic alloc_has_value;
    logic [DATA_W-1:0] alloc_value;
    logic [IDX_W-1:0]  alloc_idx;
    logic [NUM_CDB-1:0] cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_data;
    logic commit_valid;
    logic commit_ready;
    logic [DEST_W-1:0] commit_dest;
    logic [DATA_W-1:0] commit_data;
    logic [TAG_W-1:0]  commit_tag;
    logic [IDX_W-1:0]  commit_idx;
    logic [DEPTH-1:0]  busy;
    logic [IDX_W:0]    count;
    logic full;
    logic empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DEST_W-1:0] dest;
        logic [TAG_W-1:0]  tag;
        bit                rdy;
        logic [DATA_W-1:0] val;
    } ent_t;

    // Model: the window is a FIFO of in-flight entries, oldest first
    ent_t q[$];
    int   head_m = 0;

    rob_circular #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .DEST_W(DEST_W), .NUM_CDB(NUM_CDB), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_dest(alloc_dest), .alloc_tag(alloc_tag),
        .alloc_has_value(alloc_has_value), .alloc_value(alloc_value),
        .alloc_idx(alloc_idx),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_dest(commit_dest), .commit_data(commit_data),
        .commit_tag(commit_tag), .commit_idx(commit_idx),
        .busy(busy), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        head_m = 0;
    endtask

    // Compare every visible output against the model's current window
    task automatic check_outputs();
        int n = q.size();
        logic [DEPTH-1:0] bm = '0;
        bit cv = (n > 0) && q[0].rdy;
        for (int i = 0; i < n; i++) bm[(head_m + i) % DEPTH] = 1'b1;
        chk("alloc_ready", alloc_ready, n < DEPTH);
        chk("alloc_idx", alloc_idx, (head_m + n) % DEPTH);
        chk("commit_idx", commit_idx, head_m);
        chk("count", count, n);
        chk("full", full, n == DEPTH);
        chk("empty", empty, n == 0);
        chk("busy", busy, bm);
        chk("commit_valid", commit_valid, cv);
        if (cv) begin
            chk("commit_dest", commit_dest, q[0].dest);
            chk("commit_data", commit_data, q[0].val);
            chk("commit_tag", commit_tag, q[0].tag);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        bit af = alloc_valid && (q.size() < DEPTH);
        bit cf = (q.size() > 0) && q[0].rdy && commit_ready;
        ent_t e;
        if (flush) begin
            model_reset();
            return;
        end
        foreach (q[i]) begin
            if (!q[i].rdy) begin
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == q[i].tag) begin
                        q[i].rdy = 1'b1;
                        q[i].val = cdb_data[k*DATA_W +: DATA_W];
                        break;
                    end
                end
            end
        end
        if (cf) begin
            void'(q.pop_front());
            head_m = (head_m + 1) % DEPTH;
        end
        if (af) begin
            e.dest = alloc_dest;
            e.tag  = alloc_tag;
            e.rdy  = alloc_has_value;
            e.val  = alloc_value;
            q.push_back(e);
        end
    endtask

    // One clock: inputs already applied, check at negedge, step model, land at posedge+1
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; alloc_valid = 0; alloc_dest = '0; alloc_tag = '0;
        alloc_has_value = 0; alloc_value = '0; commit_ready = 0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic set_alloc(input int d, input int t, input bit hv, input logic [31:0] v);
        alloc_valid = 1; alloc_dest = DEST_W'(d); alloc_tag = TAG_W'(t);
        alloc_has_value = hv; alloc_value = v;
    endtask

    task automatic set_cdb(input int k, input int t, input logic [31:0] d);
        cdb_valid[k] = 1'b1;
        cdb_tag[k*TAG_W +: TAG_W] = TAG_W'(t);
        cdb_data[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_flush();
        idle_inputs();
        flush = 1;
        cycle();
        flush = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        model_reset();
        #7;
        // Reset state
        chk("rst_empty", empty, 1);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_alloc_idx", alloc_idx, 0);
        chk("rst_commit_data", commit_data, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        cycle();
        cycle();

        // Three allocations resolved out of order, committed in order
        set_alloc(1, 7, 0, 0); cycle();
        set_alloc(2, 8, 0, 0); cycle();
        set_alloc(3, 9, 0, 0); cycle();
        idle_inputs();
        commit_ready = 1;
        set_cdb(1, 9, 32'h33); cycle();
        idle_inputs(); commit_ready = 1;
        set_cdb(0, 7, 32'h11); cycle();
        idle_inputs(); commit_ready = 1;
        set_cdb(0, 8, 32'h22); cycle();
        idle_inputs(); commit_ready = 1;
        for (int i = 0; i < 4; i++) cycle();
        chk("drain_count", count, 0);

        // Fill to full, then commit-only, then simultaneous alloc+commit
        do_flush();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(i + 10, i, 1, 32'h100 + i);
            cycle();
        end
        chk("fill_full", full, 1);
        chk("fill_alloc_ready", alloc_ready, 0);
        chk("fill_count", 64'(count), 64'(DEPTH));
        set_alloc(20, 3, 1, 32'hAA); commit_ready = 1;
        cycle();
        chk("full_commit_count", count, 7);
        set_alloc(21, 4, 1, 32'hBB); commit_ready = 1;
        cycle();
        chk("both_count", count, 7);
        chk("both_alloc_idx", alloc_idx, 1);
        chk("both_commit_idx", commit_idx, 2);

        // Multi-channel match: lowest channel wins
        do_flush();
        set_alloc(4, 10, 0, 0); cycle();
        idle_inputs();
        set_cdb(2, 10, 32'hA); set_cdb(4, 10, 32'hB);
        cycle();
        idle_inputs();
        chk("multi_match_data", commit_data, 32'hA);
        chk("multi_match_valid", commit_valid, 1);
        commit_ready = 1; cycle();

        // Value known at allocation; CDB on its tag is ignored
        do_flush();
        set_alloc(6, 5, 1, 32'h55); cycle();
        idle_inputs();
        chk("hv_commit_valid", commit_valid, 1);
        chk("hv_commit_data", commit_data, 32'h55);
        set_cdb(0, 5, 32'h99); cycle();
        idle_inputs();
        chk("hv_ignore_cdb", commit_data, 32'h55);
        commit_ready = 1; cycle();

        // Flush with 5 entries busy and a concurrent alloc request
        do_flush();
        for (int i = 0; i < 5; i++) begin
            set_alloc(i, i, i[0], 32'(i)); cycle();
        end
        set_alloc(9, 9, 1, 32'h9); flush = 1; commit_ready = 1;
        cycle();
        idle_inputs();
        chk("flush_count", count, 0);
        chk("flush_busy", busy, 0);
        chk("flush_alloc_idx", alloc_idx, 0);
        chk("flush_commit_idx", commit_idx, 0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            idle_inputs();
            flush = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 2) != 0)
                set_alloc($urandom_range(0, 31), $urandom_range(0, 15),
                          $urandom_range(0, 3) == 0, $urandom());
            commit_ready = ($urandom_range(0, 9) < 7);
            for (int k = 0; k < NUM_CDB; k++)
                if ($urandom_range(0, 9) < 3)
                    set_cdb(k, $urandom_range(0, 15), $urandom());
            cycle();
        end

        // Asynchronous reset in the middle of a commit handshake
        do_flush();
        set_alloc(7, 2, 1, 32'h77); cycle();
        idle_inputs();
        commit_ready = 1;
        #2;
        rst = 1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_commit_valid", commit_valid, 0);
        chk("async_rst_empty", empty, 1);
        model_reset();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        idle_inputs();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
